// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: three-stage IEEE-754-style multiplier (FP16 by default) with valid/ready handshakes.
// Define FP_MULT_RNE_EN for round-to-nearest-even; when it is undefined, results are truncated toward zero.
module fp_mult_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_product,
  output logic [1:0]           out_exc
);

  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int SW     = MAN_W + 1;
  localparam int PW     = 2 * SW;
  localparam int EW2    = EXP_W + 2;
  localparam int STAGES = 3;

  localparam logic signed [EW2-1:0] BIAS  = EW2'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW2-1:0] EMAX  = EW2'((1 << EXP_W) - 1);
  localparam logic signed [EW2-1:0] EZERO = '0;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_OVF  = 2'b01;
  localparam logic [1:0] EXC_UNF  = 2'b10;
  localparam logic [1:0] EXC_NAN  = 2'b11;

  typedef struct packed {
    logic           sign;
    logic           nan;
    logic           inf;
    logic           zero;
    logic [EW2-1:0] exp;
    logic [SW-1:0]  man_a;
    logic [SW-1:0]  man_b;
  } s1_t;

  typedef struct packed {
    logic           sign;
    logic           nan;
    logic           inf;
    logic           zero;
    logic [EW2-1:0] exp;
    logic [PW-1:0]  prod;
  } s2_t;

  s1_t              r_s1;
  s2_t              r_s2;
  logic [STAGES:1]  r_vld_pipe;
  logic [W-1:0]     r_out_product;
  logic [1:0]       r_out_exc;

  logic             w_advance;

  // ---------------- S1: unpack / classify ----------------
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W-1:0] w_fa, w_fb;
  logic             w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic             w_nan, w_inf, w_zero;
  logic signed [EW2-1:0] w_exp_sum;
  s1_t              w_s1;

  assign w_ea = in_a[W-2 -: EXP_W];
  assign w_eb = in_b[W-2 -: EXP_W];
  assign w_fa = in_a[MAN_W-1:0];
  assign w_fb = in_b[MAN_W-1:0];

  // A zero exponent field covers both true zero and flushed subnormals.
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_inf  = (&w_ea) && (w_fa == '0);
  assign w_b_inf  = (&w_eb) && (w_fb == '0);
  assign w_a_nan  = (&w_ea) && (w_fa != '0);
  assign w_b_nan  = (&w_eb) && (w_fb != '0);

  assign w_nan  = w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_a_zero && w_b_inf);
  assign w_inf  = !w_nan && (w_a_inf || w_b_inf);
  assign w_zero = !w_nan && !w_inf && (w_a_zero || w_b_zero);

  assign w_exp_sum = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - BIAS;

  always_comb begin
    w_s1       = '0;
    w_s1.sign  = in_a[W-1] ^ in_b[W-1];
    w_s1.nan   = w_nan;
    w_s1.inf   = w_inf;
    w_s1.zero  = w_zero;
    w_s1.exp   = w_exp_sum;
    w_s1.man_a = {1'b1, w_fa};
    w_s1.man_b = {1'b1, w_fb};
  end

  // ---------------- S2: mantissa multiply ----------------
  s2_t w_s2;

  always_comb begin
    w_s2      = '0;
    w_s2.sign = r_s1.sign;
    w_s2.nan  = r_s1.nan;
    w_s2.inf  = r_s1.inf;
    w_s2.zero = r_s1.zero;
    w_s2.exp  = r_s1.exp;
    w_s2.prod = PW'(r_s1.man_a) * PW'(r_s1.man_b);
  end

  // ---------------- S3: normalise, round, pack ----------------
  logic             w_msb;
  logic [MAN_W-1:0] w_frac;
  logic             w_rnd_up;
  logic [MAN_W:0]   w_frac_r;
  logic signed [EW2-1:0] w_exp_f;
  logic [W-1:0]     w_res;
  logic [1:0]       w_exc;

  // Product lies in [1,4): MSB set means the value is >= 2 and the fraction window moves up one bit.
  assign w_msb  = r_s2.prod[PW-1];
  assign w_frac = w_msb ? r_s2.prod[PW-2 -: MAN_W] : r_s2.prod[PW-3 -: MAN_W];

`ifdef FP_MULT_RNE_EN
  logic w_guard, w_sticky;
  assign w_guard  = w_msb ? r_s2.prod[PW-2-MAN_W] : r_s2.prod[PW-3-MAN_W];
  assign w_sticky = w_msb ? (|r_s2.prod[PW-3-MAN_W:0]) : (|r_s2.prod[PW-4-MAN_W:0]);
  assign w_rnd_up = w_guard && (w_sticky || w_frac[0]);
`else
  logic w_lsb_unused;
  assign w_lsb_unused = |r_s2.prod[MAN_W-1:0];
  assign w_rnd_up     = 1'b0;
`endif

  // A carry out of the fraction means 1.11..1 rounded up to 10.0: the fraction is already zero.
  assign w_frac_r = {1'b0, w_frac} + {{MAN_W{1'b0}}, w_rnd_up};
  assign w_exp_f  = $signed(r_s2.exp)
                  + $signed({{(EW2-1){1'b0}}, w_msb})
                  + $signed({{(EW2-1){1'b0}}, w_frac_r[MAN_W]});

  always_comb begin
    w_res = '0;
    w_exc = EXC_NONE;
    if (r_s2.nan) begin
      w_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      w_exc = EXC_NAN;
    end else if (r_s2.inf) begin
      w_res = {r_s2.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (r_s2.zero) begin
      w_res = {r_s2.sign, {(W-1){1'b0}}};
    end else if (w_exp_f >= EMAX) begin
      w_res = {r_s2.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_exc = EXC_OVF;
    end else if (w_exp_f <= EZERO) begin
      w_res = {r_s2.sign, {(W-1){1'b0}}};
      w_exc = EXC_UNF;
    end else begin
      w_res = {r_s2.sign, w_exp_f[EXP_W-1:0], w_frac_r[MAN_W-1:0]};
    end
  end

  // ---------------- pipeline control ----------------
  // Whole pipe moves in lockstep; bubbles are carried, not squeezed out.
  assign w_advance = !r_vld_pipe[STAGES] || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe    <= '0;
      r_s1          <= '0;
      r_s2          <= '0;
      r_out_product <= '0;
      r_out_exc     <= EXC_NONE;
    end else if (w_advance) begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], in_valid};
      if (in_valid)      r_s1 <= w_s1;
      if (r_vld_pipe[1]) r_s2 <= w_s2;
      if (r_vld_pipe[2]) begin
        r_out_product <= w_res;
        r_out_exc     <= w_exc;
      end
    end
  end

  assign in_ready    = w_advance;
  assign out_valid   = r_vld_pipe[STAGES];
  assign out_product = r_out_product;
  assign out_exc     = r_out_exc;

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed scoreboard bench for fp_mult_pipe (FP16 defaults); expectations follow FP_MULT_RNE_EN.
module tb_fp_mult_pipe;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_product;
  logic [1:0]   out_exc;

  int vectors = 0;
  int miscompares = 0;
  logic [W+1:0] exp_q[$];
  string        tag_q[$];

  fp_mult_pipe #(.EXP_W(5), .MAN_W(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_exc(out_exc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every output transfer pops the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      check("output_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        logic [W+1:0] e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, 32'({out_product, out_exc}), 32'(e));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] p, input logic [1:0] e);
    bit acc = 1'b0;
    int n = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    exp_q.push_back({p, e});
    tag_q.push_back(tag);
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    check({tag, "_accept"}, 32'(acc), 32'd1);
  endtask

  task automatic latency(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 10);
    check(tag, 32'(n), 32'd3);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_product", 32'(out_product), 32'd0);
    check("rst_out_exc", 32'(out_exc), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    send("mul_pos", 16'h4100, 16'h4400, 16'h4900, 2'b00);
    latency("latency_first");
    drain();

    send("mul_neg_a",    16'hC100, 16'h4400, 16'hC900, 2'b00);
    send("mul_neg_ab",   16'hC100, 16'hC400, 16'h4900, 2'b00);
    send("ninf_x_zero",  16'hFC00, 16'h0000, 16'h7E00, 2'b11);
    send("nan_in",       16'h7D04, 16'h44E6, 16'h7E00, 2'b11);
    send("subn_x_zero",  16'h811E, 16'h0000, 16'h8000, 2'b00);
    send("inf_x_fin",    16'h7C00, 16'hC000, 16'hFC00, 2'b00);
    send("zero_x_fin",   16'h8000, 16'h4000, 16'h8000, 2'b00);
    send("overflow",     16'h7BFF, 16'h4000, 16'h7C00, 2'b01);
    send("underflow",    16'h0500, 16'h0906, 16'h0000, 2'b10);
    send("min_normal",   16'h0400, 16'h3C00, 16'h0400, 2'b00);
    send("exp_zero_unf", 16'h0400, 16'h3800, 16'h0000, 2'b10);
    send("max_normal",   16'h7BFF, 16'h3C00, 16'h7BFF, 2'b00);
    send("one5_sq",      16'h3E00, 16'h3E00, 16'h4080, 2'b00);
`ifdef FP_MULT_RNE_EN
    send("tie_even",     16'h3E00, 16'h3C01, 16'h3E02, 2'b00);
    send("rnd_carry",    16'h3FFE, 16'h3C01, 16'h4000, 2'b00);
    send("rnd_carry_ovf",16'h7BFE, 16'h3C01, 16'h7C00, 2'b01);
`else
    send("tie_trunc",    16'h3E00, 16'h3C01, 16'h3E01, 2'b00);
    send("trunc_nocarry",16'h3FFE, 16'h3C01, 16'h3FFF, 2'b00);
    send("trunc_noovf",  16'h7BFE, 16'h3C01, 16'h7BFF, 2'b00);
`endif
    drain();

    fork
      begin
        send("bp0", 16'h4100, 16'h4400, 16'h4900, 2'b00);
        send("bp1", 16'hC100, 16'h4400, 16'hC900, 2'b00);
        send("bp2", 16'h3E00, 16'h3E00, 16'h4080, 2'b00);
        send("bp3", 16'h7BFF, 16'h4000, 16'h7C00, 2'b01);
        send("bp4", 16'h0500, 16'h0906, 16'h0000, 2'b10);
        send("bp5", 16'h7C00, 16'hC000, 16'hFC00, 2'b00);
      end
      begin
        int n = 0;
        do begin
          @(posedge clk);
          #1;
          n++;
        end while (!out_valid && n < 20);
        check("bp_first_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("bp_in_ready", 32'(in_ready), 32'd0);
          check("bp_hold", 32'({out_valid, out_product, out_exc}), 32'({1'b1, exp_q[0]}));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    send("rst_f0", 16'h4100, 16'h4400, 16'h4900, 2'b00);
    send("rst_f1", 16'hC100, 16'h4400, 16'hC900, 2'b00);
    send("rst_f2", 16'h3E00, 16'h3E00, 16'h4080, 2'b00);
    rst_n = 1'b0;
    exp_q.delete();
    tag_q.delete();
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_product", 32'(out_product), 32'd0);
    check("midrst_out_exc", 32'(out_exc), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    send("post_rst", 16'h4100, 16'h4400, 16'h4900, 2'b00);
    latency("latency_post_rst");
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fp_mult_pipe.md
Name: fp_mult_pipe

Overview:
- Parametrised, pipelined IEEE-754-style floating-point multiplier. It succeeds the combinational half-precision hp_multiplier.
- Exponent and mantissa widths are generic; defaults give FP16.
- Three-stage pipeline with valid/ready handshakes on input and output, so it sits directly on streaming datapaths.
- Keeps the 2-bit exception code of the previous generation, with priority resolution and round-to-nearest-even.

Parameters:
- EXP_W, 5, exponent field width (bits).
- MAN_W, 10, stored mantissa (fraction) width (bits). Total word width W = 1+EXP_W+MAN_W.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts operands this cycle.
- in_a  in  W  operand A (sign|exp|frac).
- in_b  in  W  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_product  out  W  result.
- out_exc  out  2  exception code: 00 none, 01 overflow, 10 underflow, 11 invalid/NaN.

Behaviour:
- Reset (async assert, sync release): all stage valid bits 0, out_valid=0, out_product=0, out_exc=00. Reset mid-operation discards all in-flight results.
- Pipeline stages:
  - S1: unpack and classify each operand as zero, subnormal, normal, inf or NaN; sign = a.s XOR b.s; biased exponent sum.
  - S2: (MAN_W+1)x(MAN_W+1) unsigned mantissa multiply, full 2*(MAN_W+1)-bit product.
  - S3: normalise (product MSB set -> shift right 1, exponent +1), round, pack, exception resolve.
- Latency: a result is presented exactly 3 cycles after acceptance when out_ready stays 1. Throughput is 1 per cycle.
- Handshake:
  - Transfer on valid&&ready at either side.
  - advance = !out_valid || out_ready. in_ready = advance.
  - All stages shift together on advance and hold on stall. Bubbles are not collapsed.
  - out_product and out_exc stay stable while out_valid && !out_ready.
- Exponent arithmetic: signed, width EXP_W+2. e = ea+eb-BIAS, with BIAS = 2^(EXP_W-1)-1.
- Subnormal inputs are flushed to signed zero before classification. Subnormal results are never produced.
- Special cases, in priority order:
  - NaN input, or inf x zero -> canonical NaN (sign 0, exp all ones, frac MSB 1, rest 0), exc 11.
  - inf x finite nonzero -> signed inf, exc 00.
  - zero x finite -> signed zero, exc 00.
  - Finite result exponent >= 2^EXP_W-1 after rounding -> signed inf, exc 01.
  - Finite result exponent <= 0 -> signed zero, exc 10.
  - Otherwise normal result, exc 00.
- Rounding carry into the hidden bit renormalises (exponent +1). This may then raise overflow.

Optional Feature:
- Macro: FP_MULT_RNE_EN.
- Defined: round-to-nearest, ties-to-even, using guard bit plus sticky OR of all lower product bits.
- Undefined: truncation toward zero; guard/sticky logic is not generated. Latency, handshakes and exception priority are identical in both builds.

Test Plan:
- 0x4100 (2.5) x 0x4400 (4.0), out_ready=1 -> 0x4900 (10.0), exc 00, out_valid exactly 3 cycles after acceptance. Repeat with signs: 0xC100 x 0x4400 -> 0xC900; 0xC100 x 0xC400 -> 0x4900.
- Specials:
  - 0xFC00 (-inf) x 0x0000 -> 0x7E00, exc 11.
  - 0x7D04 (NaN) x 0x44E6 -> 0x7E00, exc 11.
  - 0x811E (subnormal) x 0x0000 -> 0x8000, exc 00.
- Range:
  - 0x7BFF x 0x4000 -> 0x7C00, exc 01.
  - 0x0500 x 0x0906 -> 0x0000, exc 10.
  - 0x3E00 x 0x3E00 (1.5 x 1.5) -> 0x4080, exc 00.
- Rounding tie, 0x3E00 x 0x3C01 -> 0x3E02 with FP_MULT_RNE_EN, 0x3E01 without.
- Backpressure:
  - Stream 6 back-to-back pairs; hold out_ready=0 for 4 cycles after the first out_valid.
  - Expect in_ready=0 during the stall, out_product held constant, all 6 results in order with none lost or duplicated.
- Assert rst_n=0 with 3 results in flight, release -> out_valid=0 and no stale results emerge. The next accepted pair yields a correct result 3 cycles later.
